// File: rtl/writeback_stage_if.sv
// rtl/writeback_stage_if.sv - retire handshake, memory return and RF write port bundle
interface writeback_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_reg_write;
  logic [4:0]  in_rd;
  logic [1:0]  in_WBSel;
  logic [2:0]  in_funct3;
  logic [31:0] in_PC;
  logic [31:0] in_ALU_out;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_write_enable;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_WBSel;
  logic [31:0] wb_PC;
  logic [31:0] wb_ALU_out;
  logic [31:0] wb_dmem_out;
  logic        busy;
  logic        load_fault;

  modport slave (
    input  in_valid, in_reg_write, in_rd, in_WBSel, in_funct3, in_PC, in_ALU_out,
    input  dmem_rvalid, dmem_rdata,
    output in_ready, wb_write_enable, wb_rd, wb_WBSel, wb_PC, wb_ALU_out, wb_dmem_out,
    output busy, load_fault
  );

  modport master (
    output in_valid, in_reg_write, in_rd, in_WBSel, in_funct3, in_PC, in_ALU_out,
    output dmem_rvalid, dmem_rdata,
    input  in_ready, wb_write_enable, wb_rd, wb_WBSel, wb_PC, wb_ALU_out, wb_dmem_out,
    input  busy, load_fault
  );
endinterface

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - retires MEM-stage instructions, waits on and extends load data, drives one RF write each
module writeback_stage #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input logic              clk,
  input logic              rst,
  writeback_stage_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT} state_t;

  state_t      state, state_next;
  logic [CNT_W-1:0] cnt;
  logic        cap_reg_write;
  logic [2:0]  cap_funct3;
  logic [4:0]  rd_q;
  logic [1:0]  wbsel_q;
  logic [31:0] pc_q, alu_q, dmem_q;
  logic        we_q, fault_q;

  logic        accept, in_is_load, in_misaligned;
  logic        capture, take_data, we_next, fault_next, cnt_inc;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  assign bus.in_ready = (state == IDLE) || (state == COMMIT);
  assign accept       = bus.in_valid && bus.in_ready;
  assign in_is_load   = (bus.in_WBSel == 2'd0) && bus.in_reg_write;

  // Undefined load encodings are rejected exactly like a misaligned access.
  always_comb begin
    in_misaligned = 1'b0;
    case (bus.in_funct3)
      3'b000, 3'b100: in_misaligned = 1'b0;
      3'b001, 3'b101: in_misaligned = bus.in_ALU_out[0];
      3'b010:         in_misaligned = |bus.in_ALU_out[1:0];
      default:        in_misaligned = 1'b1;
    endcase
  end

  always_comb begin
    byte_sel = bus.dmem_rdata[7:0];
    case (alu_q[1:0])
      2'd0: byte_sel = bus.dmem_rdata[7:0];
      2'd1: byte_sel = bus.dmem_rdata[15:8];
      2'd2: byte_sel = bus.dmem_rdata[23:16];
      2'd3: byte_sel = bus.dmem_rdata[31:24];
      default: byte_sel = bus.dmem_rdata[7:0];
    endcase
    half_sel = alu_q[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
    load_ext = bus.dmem_rdata;
    case (cap_funct3)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {24'd0, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_ext = {16'd0, half_sel};
      default: load_ext = bus.dmem_rdata;
    endcase
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    take_data  = 1'b0;
    we_next    = 1'b0;
    fault_next = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      IDLE, COMMIT: begin
        state_next = IDLE;
        if (accept) begin
          capture = 1'b1;
          if (in_is_load && in_misaligned) begin
            fault_next = 1'b1;
          end else if (in_is_load) begin
            state_next = WAIT_MEM;
          end else begin
            state_next = COMMIT;
            we_next    = bus.in_reg_write && (bus.in_rd != 5'd0);
          end
        end
      end
      WAIT_MEM: begin
        // Data arriving on the final timeout cycle still counts.
        if (bus.dmem_rvalid) begin
          take_data  = 1'b1;
          state_next = COMMIT;
          we_next    = cap_reg_write && (rd_q != 5'd0);
        end else if (cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
          fault_next = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      cap_reg_write <= 1'b0;
      cap_funct3    <= 3'd0;
      rd_q          <= 5'd0;
      wbsel_q       <= 2'd0;
      pc_q          <= 32'd0;
      alu_q         <= 32'd0;
      dmem_q        <= 32'd0;
      we_q          <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      we_q    <= we_next;
      fault_q <= fault_next;
      if (capture) begin
        cap_reg_write <= bus.in_reg_write;
        cap_funct3    <= bus.in_funct3;
        rd_q          <= bus.in_rd;
        wbsel_q       <= (bus.in_WBSel == 2'd3) ? 2'd2 : bus.in_WBSel;
        pc_q          <= bus.in_PC;
        alu_q         <= bus.in_ALU_out;
        cnt           <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + 1'b1;
      end
      if (take_data) dmem_q <= load_ext;
    end
  end

  assign bus.wb_write_enable = we_q;
  assign bus.wb_rd           = rd_q;
  assign bus.wb_WBSel        = wbsel_q;
  assign bus.wb_PC           = pc_q;
  assign bus.wb_ALU_out      = alu_q;
  assign bus.wb_dmem_out     = dmem_q;
  assign bus.busy            = (state != IDLE);
  assign bus.load_fault      = fault_q;
endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - randomized and directed checks of writeback_stage against a transaction-level model
module tb_writeback_stage;
  localparam int T = 16;

  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  writeback_stage_if bus();

  writeback_stage #(.MEM_TIMEOUT(T), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.in_valid     = 1'b0;
    bus.in_reg_write = 1'($urandom);
    bus.in_rd        = 5'($urandom);
    bus.in_WBSel     = 2'($urandom);
    bus.in_funct3    = 3'($urandom);
    bus.in_PC        = $urandom;
    bus.in_ALU_out   = $urandom;
    bus.dmem_rvalid  = 1'b0;
    bus.dmem_rdata   = $urandom;
  endtask

  function automatic int access_size(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic logic model_fault(input logic [2:0] f3, input logic [31:0] addr);
    int sz;
    sz = access_size(f3);
    return (sz == 0) || ((addr % sz) != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    int sz;
    int unsigned off;
    longint v;
    sz  = access_size(f3);
    off = addr % 4;
    if (sz == 4) return rdata;
    v = longint'(rdata >> (8 * off)) % (longint'(1) << (8 * sz));
    if ((f3 == 3'd0 || f3 == 3'd1) && v >= (longint'(1) << (8 * sz - 1)))
      v = v - (longint'(1) << (8 * sz));
    return 32'(v);
  endfunction

  task automatic run_instr(input logic rw, input logic [4:0] rd, input logic [1:0] wbsel,
                           input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] alu,
                           input int delay, input logic [31:0] rdata,
                           output logic got_we, output logic got_fault, output logic [31:0] got_dmem);
    logic is_load, exp_we, saw_early;
    logic [1:0] exp_sel;
    int guard;
    is_load = (wbsel == 2'd0) && rw;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 40) begin
      tick;
      guard++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait: in_ready=%b required 1", bus.in_ready);
    end
    bus.in_reg_write = rw;
    bus.in_rd        = rd;
    bus.in_WBSel     = wbsel;
    bus.in_funct3    = f3;
    bus.in_PC        = pc;
    bus.in_ALU_out   = alu;
    bus.in_valid     = 1'b1;
    tick;
    idle_inputs;
    if (is_load && model_fault(f3, alu)) begin
      checks++;
      if (bus.load_fault !== 1'b1 || bus.wb_write_enable !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL misaligned_fault: fault=%b we=%b busy=%b required 1 0 0 (f3=%0d addr=%h)",
                 bus.load_fault, bus.wb_write_enable, bus.busy, f3, alu);
      end
    end else if (is_load) begin
      saw_early = 1'b0;
      for (int c = 0; c < T; c++) begin
        if (bus.wb_write_enable !== 1'b0 || bus.load_fault !== 1'b0 || bus.busy !== 1'b1)
          saw_early = 1'b1;
        bus.dmem_rvalid = (c == delay);
        bus.dmem_rdata  = (c == delay) ? rdata : $urandom;
        tick;
        if (c == delay) break;
      end
      bus.dmem_rvalid = 1'b0;
      checks++;
      if (saw_early) begin
        errors++;
        $display("FAIL wait_quiet: write, fault or idle seen while waiting for data (delay=%0d)", delay);
      end
      if (delay < T) begin
        exp_we = (rd != 5'd0);
        checks++;
        if (bus.wb_write_enable !== exp_we || bus.wb_dmem_out !== model_load(f3, alu, rdata) ||
            bus.wb_rd !== rd || bus.load_fault !== 1'b0) begin
          errors++;
          $display("FAIL load_commit: we=%b dmem=%h rd=%0d fault=%b required %b %h %0d 0",
                   bus.wb_write_enable, bus.wb_dmem_out, bus.wb_rd, bus.load_fault,
                   exp_we, model_load(f3, alu, rdata), rd);
        end
      end else begin
        checks++;
        if (bus.load_fault !== 1'b1 || bus.wb_write_enable !== 1'b0 || bus.in_ready !== 1'b1) begin
          errors++;
          $display("FAIL load_timeout: fault=%b we=%b ready=%b required 1 0 1",
                   bus.load_fault, bus.wb_write_enable, bus.in_ready);
        end
      end
    end else begin
      exp_we  = rw && (rd != 5'd0);
      exp_sel = (wbsel == 2'd3) ? 2'd2 : wbsel;
      checks++;
      if (bus.wb_write_enable !== exp_we || bus.wb_rd !== rd || bus.wb_WBSel !== exp_sel ||
          bus.wb_PC !== pc || bus.wb_ALU_out !== alu || bus.load_fault !== 1'b0) begin
        errors++;
        $display("FAIL commit: we=%b rd=%0d sel=%0d pc=%h alu=%h required %b %0d %0d %h %h",
                 bus.wb_write_enable, bus.wb_rd, bus.wb_WBSel, bus.wb_PC, bus.wb_ALU_out,
                 exp_we, rd, exp_sel, pc, alu);
      end
    end
    got_we    = bus.wb_write_enable;
    got_fault = bus.load_fault;
    got_dmem  = bus.wb_dmem_out;
    tick;
    checks++;
    if (bus.wb_write_enable !== 1'b0 || bus.load_fault !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse: we=%b fault=%b busy=%b required 0 0 0",
               bus.wb_write_enable, bus.load_fault, bus.busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_inputs;
    tick;
    tick;
    checks++;
    if (bus.wb_write_enable !== 1'b0 || bus.wb_rd !== 5'd0 || bus.wb_WBSel !== 2'd0 ||
        bus.wb_PC !== 32'd0 || bus.wb_ALU_out !== 32'd0 || bus.wb_dmem_out !== 32'd0 ||
        bus.busy !== 1'b0 || bus.load_fault !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: we=%b rd=%0d pc=%h alu=%h dmem=%h busy=%b fault=%b ready=%b required all 0, ready 1",
               bus.wb_write_enable, bus.wb_rd, bus.wb_PC, bus.wb_ALU_out, bus.wb_dmem_out,
               bus.busy, bus.load_fault, bus.in_ready);
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_directed;
    logic w, f;
    logic [31:0] d;
    run_instr(1'b1, 5'd5, 2'd1, 3'd0, 32'h100, 32'h1234, 0, 32'd0, w, f, d);
    checks++;
    if (w !== 1'b1) begin errors++; $display("FAIL alu_op_we: got %b required 1", w); end
    run_instr(1'b1, 5'd7, 2'd0, 3'b000, 32'h104, 32'h0000_1003, 3, 32'h80FF_FFFF, w, f, d);
    checks++;
    if (d !== 32'hFFFF_FF80 || w !== 1'b1) begin
      errors++; $display("FAIL lb_sign: dmem=%h we=%b required ffffff80 1", d, w);
    end
    run_instr(1'b1, 5'd8, 2'd0, 3'b101, 32'h108, 32'h0000_2002, 1, 32'hBEEF_0000, w, f, d);
    checks++;
    if (d !== 32'h0000_BEEF) begin errors++; $display("FAIL lhu_zero: dmem=%h required 0000beef", d); end
    run_instr(1'b1, 5'd9, 2'd0, 3'b001, 32'h10C, 32'h0000_2001, 0, 32'd0, w, f, d);
    checks++;
    if (f !== 1'b1 || w !== 1'b0) begin errors++; $display("FAIL lh_misaligned: fault=%b we=%b required 1 0", f, w); end
    run_instr(1'b1, 5'd0, 2'd2, 3'd0, 32'h110, 32'h0, 0, 32'd0, w, f, d);
    checks++;
    if (w !== 1'b0) begin errors++; $display("FAIL jal_rd0: we=%b required 0", w); end
    run_instr(1'b1, 5'd1, 2'd2, 3'd0, 32'h114, 32'h0, 0, 32'd0, w, f, d);
    checks++;
    if (w !== 1'b1 || bus.wb_PC !== 32'h114) begin errors++; $display("FAIL jal_rd1: we=%b pc=%h required 1 00000114", w, bus.wb_PC); end
  endtask

  task automatic test_timeout;
    logic w, f;
    logic [31:0] d;
    run_instr(1'b1, 5'd3, 2'd0, 3'b010, 32'h200, 32'h0000_3000, T + 5, 32'h1234_5678, w, f, d);
    checks++;
    if (f !== 1'b1 || w !== 1'b0) begin errors++; $display("FAIL timeout_fault: fault=%b we=%b required 1 0", f, w); end
    run_instr(1'b1, 5'd4, 2'd0, 3'b010, 32'h204, 32'h0000_3004, T - 1, 32'hCAFE_F00D, w, f, d);
    checks++;
    if (w !== 1'b1 || d !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL timeout_edge_data: we=%b dmem=%h required 1 cafef00d", w, d);
    end
  endtask

  task automatic test_random;
    logic w, f;
    logic [31:0] d;
    logic [2:0] f3;
    logic [1:0] sel;
    for (int i = 0; i < 60; i++) begin
      f3  = 3'($urandom);
      sel = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom);
      run_instr(1'($urandom_range(0, 3) != 0), 5'($urandom), sel, f3, $urandom,
                $urandom, $urandom_range(0, T + 2), $urandom, w, f, d);
    end
  endtask

  task automatic test_back_to_back;
    logic [4:0] rd;
    logic rw;
    logic [31:0] alu;
    int exp_writes, got_writes;
    exp_writes = 0;
    got_writes = 0;
    for (int i = 0; i < 20; i++) begin
      rd  = 5'($urandom);
      rw  = 1'($urandom);
      alu = $urandom;
      bus.in_valid     = 1'b1;
      bus.in_reg_write = rw;
      bus.in_rd        = rd;
      bus.in_WBSel     = 2'($urandom_range(1, 3));
      bus.in_funct3    = 3'($urandom);
      bus.in_PC        = $urandom;
      bus.in_ALU_out   = alu;
      if (rw && rd != 5'd0) exp_writes++;
      tick;
      if (bus.wb_write_enable === 1'b1) got_writes++;
      checks++;
      if (bus.wb_write_enable !== (rw && rd != 5'd0) || bus.wb_ALU_out !== alu ||
          bus.wb_rd !== rd || bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_op%0d: we=%b alu=%h rd=%0d ready=%b required %b %h %0d 1",
                 i, bus.wb_write_enable, bus.wb_ALU_out, bus.wb_rd, bus.in_ready,
                 rw && rd != 5'd0, alu, rd);
      end
    end
    idle_inputs;
    tick;
    checks++;
    if (got_writes != exp_writes || bus.wb_write_enable !== 1'b0) begin
      errors++;
      $display("FAIL b2b_count: writes=%0d we_after=%b required %0d 0",
               got_writes, bus.wb_write_enable, exp_writes);
    end
  endtask

  task automatic test_reset_abort;
    logic bad;
    bus.in_valid = 1'b1; bus.in_reg_write = 1'b1; bus.in_rd = 5'd6; bus.in_WBSel = 2'd0;
    bus.in_funct3 = 3'b010; bus.in_ALU_out = 32'h4000; bus.in_PC = 32'h300;
    tick;
    idle_inputs;
    tick;
    tick;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.wb_rd !== 5'd0 || bus.wb_ALU_out !== 32'd0 ||
        bus.wb_PC !== 32'd0 || bus.wb_write_enable !== 1'b0 || bus.load_fault !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_wait: busy=%b rd=%0d alu=%h pc=%h required all 0",
               bus.busy, bus.wb_rd, bus.wb_ALU_out, bus.wb_PC);
    end
    tick;
    rst = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 4; c++) begin
      bus.dmem_rvalid = 1'b1;
      tick;
      if (bus.wb_write_enable !== 1'b0 || bus.load_fault !== 1'b0 || bus.busy !== 1'b0) bad = 1'b1;
    end
    bus.dmem_rvalid = 1'b0;
    checks++;
    if (bad) begin errors++; $display("FAIL rst_abort_quiet: write/fault/busy after reset abort, required none"); end
    bus.in_valid = 1'b1; bus.in_reg_write = 1'b1; bus.in_rd = 5'd3; bus.in_WBSel = 2'd1;
    bus.in_ALU_out = 32'h55;
    tick;
    idle_inputs;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.wb_write_enable !== 1'b0 || bus.wb_rd !== 5'd0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_commit: we=%b rd=%0d busy=%b required 0 0 0",
               bus.wb_write_enable, bus.wb_rd, bus.busy);
    end
    tick;
    rst = 1'b0;
    tick;
  endtask

  initial begin
    test_reset;
    test_directed;
    test_timeout;
    test_back_to_back;
    test_random;
    test_reset_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
